// File: rtl/contador_sincrono.sv
// Synchronous binary up-counter built from T flip-flops with AND-carry toggle
// enables, optional modulus truncation and a terminal-count decode.
module contador_sincrono #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 16
) (
    input  logic             clk,
    input  logic             clr,
    output logic [WIDTH-1:0] q,
    output logic             tc
);

    generate
        if (WIDTH < 1 || WIDTH > 16) begin : g_bad_width
            $error("contador_sincrono: WIDTH must be within 1..16");
        end
        if (MODULUS < 2 || MODULUS > (2 ** WIDTH)) begin : g_bad_modulus
            $error("contador_sincrono: MODULUS must be within 2..2**WIDTH");
        end
    endgenerate

    localparam logic [WIDTH-1:0] LAST     = WIDTH'(MODULUS - 1);
    localparam bit               TRUNCATE = (MODULUS < (2 ** WIDTH));

    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] toggle;
    logic             at_last;
    logic             wrap;

    assign at_last = (q_reg == LAST);
    // A power-of-two modulus wraps naturally through the carry chain.
    assign wrap    = TRUNCATE && at_last;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            if (gi == 0) begin : g_lsb
                assign toggle[gi] = 1'b1;
            end else begin : g_carry
                assign toggle[gi] = toggle[gi-1] & q_reg[gi-1];
            end
            assign q_next[gi] = wrap ? 1'b0 : (q_reg[gi] ^ toggle[gi]);
        end
    endgenerate

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            q_reg <= '0;
        end else begin
            q_reg <= q_next;
        end
    end

    assign q  = q_reg;
    assign tc = clr & at_last;

endmodule

// File: tb/tb_contador_sincrono.sv
// Checks a modulo-16 and a modulo-10 counter against a modular-arithmetic model
// through directed reset/wrap scenarios and a randomized reset/count phase.
module tb_contador_sincrono;

    logic       clk;
    logic       clr;
    logic [3:0] q16;
    logic       tc16;
    logic [3:0] q10;
    logic       tc10;

    int n_assert = 0;
    int n_fail   = 0;
    int e16      = 0;
    int e10      = 0;

    contador_sincrono #(.WIDTH(4), .MODULUS(16)) dut16 (
        .clk(clk), .clr(clr), .q(q16), .tc(tc16)
    );

    contador_sincrono #(.WIDTH(4), .MODULUS(10)) dut10 (
        .clk(clk), .clr(clr), .q(q10), .tc(tc10)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".q16"}, {12'd0, q16}, 16'(e16));
        chk({tag, ".tc16"}, {15'd0, tc16}, {15'd0, (clr === 1'b1) && (e16 == 15)});
        chk({tag, ".q10"}, {12'd0, q10}, 16'(e10));
        chk({tag, ".tc10"}, {15'd0, tc10}, {15'd0, (clr === 1'b1) && (e10 == 9)});
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        #1;
        if (clr) begin
            e16 = (e16 + 1) % 16;
            e10 = (e10 + 1) % 10;
        end else begin
            e16 = 0;
            e10 = 0;
        end
        chk_all(tag);
    endtask

    task automatic async_reset(input string tag);
        clr = 1'b0;
        e16 = 0;
        e10 = 0;
        #1;
        chk_all(tag);
    endtask

    task automatic release_clr();
        clr = 1'b1;
        #1;
        chk_all("release");
    endtask

    initial begin
        // Power-up reset with the clock running
        clr = 1'b1;
        #1;
        async_reset("por");
        tick("por_hold");
        tick("por_hold");
        release_clr();

        // Full count, wrap, and one step past the wrap
        for (int i = 0; i < 17; i++) begin
            tick("count");
            $display("count edge %0d: q16=%0d tc16=%0b q10=%0d tc10=%0b", i + 1, q16, tc16, q10, tc10);
        end

        // Decade counter never shows 10..15
        for (int i = 0; i < 30; i++) begin
            tick("decade");
            n_assert++;
            assert (q10 < 4'd10) else begin
                n_fail++;
                $error("FAIL decade_range: observed %0d expected <10", q10);
            end
        end

        // Mid-count asynchronous reset at q16 == 9
        while (e16 != 9) tick("to9");
        #4;
        async_reset("mid_reset");
        tick("mid_hold");
        tick("mid_hold");
        release_clr();
        tick("mid_release");
        $display("mid-count reset: q16=%0d after first edge post-release", q16);

        // Reset coincident with a rising edge at q16 == 7
        while (e16 != 7) tick("to7");
        @(posedge clk);
        clr = 1'b0;
        e16 = 0;
        e10 = 0;
        #1;
        chk_all("coincident");
        $display("coincident reset: q16=%0d q10=%0d", q16, q10);
        tick("coin_hold");
        release_clr();

        // Randomized counting with interleaved resets
        for (int i = 0; i < 300; i++) begin
            int r;
            r = $urandom_range(0, 19);
            if (r == 0) begin
                #($urandom_range(1, 8));
                async_reset("rnd_async");
                repeat ($urandom_range(0, 2)) tick("rnd_hold");
                release_clr();
            end else if (r == 1) begin
                @(posedge clk);
                clr = 1'b0;
                e16 = 0;
                e10 = 0;
                #1;
                chk_all("rnd_coin");
                release_clr();
            end else begin
                tick("rnd");
            end
            $display("rnd %0d: r=%0d q16=%0d q10=%0d", i, r, q16, q10);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/contador_sincrono.md
Name: contador_sincrono

Overview:
- Synchronous binary up-counter. All state flip-flops share one clock, so every bit changes on the same edge; there is no ripple.
- Built as a chain of toggle (T) flip-flops with AND-carry toggle enables.
- Optional modulus truncation and a terminal-count flag for cascading or decoding.
- Used as a free-running counter stage in the digital-circuits lab datapath.

Parameters:
- WIDTH, 4, counter width in bits (1..16).
- MODULUS, 16, count length. Sequence is 0..MODULUS-1. Legal range 2 <= MODULUS <= 2**WIDTH; elaboration error otherwise.

Ports:
- clk  input  1  rising-edge clock, single clock domain.
- clr  input  1  asynchronous active-low reset; 0 clears the counter immediately.
- q  output  WIDTH  current count value, registered.
- tc  output  1  terminal count, high while q == MODULUS-1 and clr is high.

Behaviour:
- Port order is clk, clr, q, tc, so positional instantiation with three connections (clk, clr, q) is valid and leaves tc unconnected.
- Reset:
  - clr=0 forces q=0 asynchronously, with no clock needed. q holds 0 for as long as clr=0, regardless of clk.
  - tc=0 while clr=0.
- Release:
  - After clr goes 0->1, the first rising clk edge moves q 0->1.
  - No extra synchronizer stage; release timing relative to the edge is the user's responsibility.
- Counting, each rising clk edge with clr=1:
  - If q == MODULUS-1, next q = 0.
  - Otherwise next q = q+1.
  - No enable input: the counter counts on every edge.
- Structure:
  - Bit i is a T flip-flop with asynchronous active-low clear.
  - Toggle enable t[0]=1, t[i]=q[0]&...&q[i-1].
  - When MODULUS < 2**WIDTH, the terminal-count condition overrides the toggles so all bits load 0 synchronously on that edge.
  - A power-of-two MODULUS reduces to the natural binary wrap.
- tc:
  - Combinational decode of q == MODULUS-1, gated by clr.
  - Rises after the edge that reaches MODULUS-1; falls after the wrap edge.
- Latency: q updates one clk edge after the count condition; tc follows q combinationally with zero cycles of latency.
- Wrap-around: MODULUS-1 -> 0 with no skipped or repeated state and no glitch states on q. All bits come from flops on the same edge.
- Reset mid-count: asserting clr at any point, including coincident with a clk edge, yields q=0. Clear has priority over the clock.
- No X on q after the first clr assertion; state before the first reset is undefined.

Test Plan:
- Power-up reset: WIDTH=4, MODULUS=16, clk period 20 ns, clr=0 for 20 ns -> q=0, tc=0 throughout, with clk toggling.
- Full count: release clr, apply 15 rising edges -> q steps 1,2,...,15 exactly one per edge; tc=1 only while q=15.
- Wrap: 16th edge after release -> q=0 and tc=0. The 17th edge gives q=1, so over 320 ns (16 edges) q returns to 0.
- Async reset mid-count: count to q=9, pull clr=0 between edges -> q=0 immediately without waiting for a clock edge. q stays 0 across two further edges while clr=0; after release, next edge gives q=1.
- Decade modulus: WIDTH=4, MODULUS=10 -> sequence 0..9 with tc=1 at q=9, next edge gives q=0; values 10..15 never appear over 30 edges.
- Reset coincident with clk edge: drop clr in the same timestep as a rising edge while q=7 -> q=0, never 8.
